mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter_pkg.sv | 16 +
 rtl/mem_port_arbiter_rr_pick2.sv | 23 ++
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and default widths for the program/data memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned AW_DEF = 8;
    localparam int unsigned DW_DEF = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_RESP  = 2'd2;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_LD  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-input round-robin picker; the caller keeps the last-owner register.
module rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       valid
);

    // req is indexed by owner ID: bit OWN_CPU is the CPU, bit OWN_LD the loader.
    always_comb begin
        valid  = |req;
        winner = OWN_CPU;
        unique case (req)
            2'b01:   winner = OWN_CPU;
            2'b10:   winner = OWN_LD;
            2'b11:   winner = ~last;
            default: winner = OWN_CPU;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port synchronous-read memory between the CPU datapath and the
// front-panel loader: IDLE -> ISSUE -> RESP per access, round-robin on ties.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_halted,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_done,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    output logic          ld_done,
    output logic [DW-1:0] ld_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_owner_q, last_owner_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] ld_rdata_q, ld_rdata_d;

    logic cpu_elig;
    logic pick_winner;
    logic pick_valid;
    logic in_issue;
    logic in_resp;

    assign cpu_elig = cpu_req & ~cpu_halted;

    rr_pick2 u_pick (
        .req    ({ld_req, cpu_elig}),
        .last   (last_owner_q),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        mem_en_d     = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        ld_rdata_d   = ld_rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d      = ST_ISSUE;
                    owner_d      = pick_winner;
                    last_owner_d = pick_winner;
                    mem_en_d     = 1'b1;
                    if (pick_winner == OWN_LD) begin
                        mem_we_d    = ld_we;
                        mem_addr_d  = ld_addr;
                        mem_wdata_d = ld_wdata;
                    end else begin
                        mem_we_d    = cpu_we;
                        mem_addr_d  = cpu_addr;
                        mem_wdata_d = cpu_wdata;
                    end
                end
            end
            ST_ISSUE: state_d = ST_RESP;
            ST_RESP: begin
                state_d = ST_IDLE;
                if (!mem_we_q) begin
                    if (owner_q == OWN_CPU) cpu_rdata_d = mem_rdata;
                    else                    ld_rdata_d  = mem_rdata;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_CPU;
            last_owner_q <= OWN_LD;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_rdata_q  <= '0;
            ld_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            ld_rdata_q   <= ld_rdata_d;
        end
    end

    assign in_issue = (state_q == ST_ISSUE);
    assign in_resp  = (state_q == ST_RESP);

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    assign cpu_gnt = in_issue & (owner_q == OWN_CPU);
    assign ld_gnt  = in_issue & (owner_q == OWN_LD);

    // A reset arriving during RESP suppresses done, so the pulse is gated by rst_n.
    assign cpu_done = in_resp & (owner_q == OWN_CPU) & rst_n;
    assign ld_done  = in_resp & (owner_q == OWN_LD) & rst_n;

    // Read data is forwarded in the done cycle, then held from the capture register.
    assign cpu_rdata = (cpu_done & ~mem_we_q) ? mem_rdata : cpu_rdata_q;
    assign ld_rdata  = (ld_done & ~mem_we_q) ? mem_rdata : ld_rdata_q;

    assign cpu_stall = cpu_req & ~cpu_done & ~cpu_halted;

endmodule
